avalon_mem_arbiter: RTL

- Two-master, one-slave Avalon-MM arbiter and wait-state sequencer for the shared testbench RAM.
- Master 0 is the CPU data port and master 1 is the CPU instruction-fetch port. The single slave port drives the RAM model.
- The RAM commits one access on each falling edge of its waitrequest input. This block generates that waitrequest, so exactly one falling edge occurs per granted transaction.

---
 rtl/avalon_mem_arbiter_if.sv | 47 ++++
 rtl/avalon_mem_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/avalon_mem_arbiter_if.sv
// Avalon-MM bundle for the two-master, one-slave RAM arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the CPU ports plus the RAM model.
interface avalon_mem_arbiter_if;
    logic [31:0] m0_address;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_writedata;
    logic [3:0]  m0_byteenable;
    logic        m0_waitrequest;

    logic [31:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_waitrequest;

    logic [31:0] m_readdata;

    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;

    modport slave (
        input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        output m0_waitrequest,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_waitrequest,
        output m_readdata,
        output s_address, s_read, s_write, s_writedata, s_byteenable, s_waitrequest,
        input  s_readdata
    );

    modport master (
        output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        input  m0_waitrequest,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_waitrequest,
        input  m_readdata,
        input  s_address, s_read, s_write, s_writedata, s_byteenable, s_waitrequest,
        output s_readdata
    );
endinterface

// File: rtl/avalon_mem_arbiter.sv
// Two-master Avalon-MM arbiter that sequences waitrequest for the shared RAM. The RAM commits once per s_waitrequest fall.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin on contention. Without it, m0 has fixed priority.
module avalon_mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset,
    avalon_mem_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic [31:0] s_address_q, s_address_d;
    logic [31:0] s_writedata_q, s_writedata_d;
    logic [3:0]  s_byteenable_q, s_byteenable_d;
    logic        s_read_q, s_read_d;
    logic        s_write_q, s_write_d;
    logic [31:0] m_readdata_q, m_readdata_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_grant_q, last_grant_d;
`endif

    logic m0_req, m1_req, winner, granted_req, enter_access;

    assign m0_req      = bus.m0_read | bus.m0_write;
    assign m1_req      = bus.m1_read | bus.m1_write;
    assign granted_req = grant_q ? m1_req : m0_req;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) winner = ~last_grant_q;
        else                  winner = ~m0_req;
`else
        winner = ~m0_req;
`endif
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        grant_d        = grant_q;
        s_address_d    = s_address_q;
        s_writedata_d  = s_writedata_q;
        s_byteenable_d = s_byteenable_q;
        s_read_d       = s_read_q;
        s_write_d      = s_write_q;
        m_readdata_d   = m_readdata_q;
        enter_access   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d        = winner;
                    s_address_d    = winner ? bus.m1_address    : bus.m0_address;
                    s_writedata_d  = winner ? bus.m1_writedata  : bus.m0_writedata;
                    s_byteenable_d = winner ? bus.m1_byteenable : bus.m0_byteenable;
                    // Read wins when read and write are raised together.
                    s_read_d       = winner ? bus.m1_read : bus.m0_read;
                    s_write_d      = winner ? (bus.m1_write & ~bus.m1_read)
                                            : (bus.m0_write & ~bus.m0_read);
                    cnt_d          = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d      = ACCESS;
                        enter_access = 1'b1;
                    end else begin
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                cnt_d = cnt_q - 4'd1;
                if (!granted_req) begin
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d      = ACCESS;
                    enter_access = 1'b1;
                end
            end
            ACCESS: begin
                if (s_read_q) m_readdata_d = bus.s_readdata;
                s_read_d  = 1'b0;
                s_write_d = 1'b0;
                state_d   = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (enter_access) last_grant_d = grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            grant_q        <= 1'b0;
            s_address_q    <= '0;
            s_writedata_q  <= '0;
            s_byteenable_q <= '0;
            s_read_q       <= 1'b0;
            s_write_q      <= 1'b0;
            m_readdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            grant_q        <= grant_d;
            s_address_q    <= s_address_d;
            s_writedata_q  <= s_writedata_d;
            s_byteenable_q <= s_byteenable_d;
            s_read_q       <= s_read_d;
            s_write_q      <= s_write_d;
            m_readdata_q   <= m_readdata_d;
        end
    end

    // Waitrequests decode from registered state only, so no input reaches an output combinationally.
    assign bus.s_waitrequest  = (state_q != ACCESS);
    assign bus.m0_waitrequest = !((state_q == DONE) && !grant_q);
    assign bus.m1_waitrequest = !((state_q == DONE) && grant_q);
    assign bus.m_readdata     = m_readdata_q;
    assign bus.s_address      = s_address_q;
    assign bus.s_writedata    = s_writedata_q;
    assign bus.s_byteenable   = s_byteenable_q;
    assign bus.s_read         = s_read_q;
    assign bus.s_write        = s_write_q;

    logic unused_enter_access;
    assign unused_enter_access = enter_access;
endmodule
